// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
// Measures the high time and the period of a hobby-servo PWM signal and
// presents each complete measurement through a valid/ready output.
//
// Ports
//   CLK          system clock, all logic on the rising edge
//   RST          synchronous active-high reset
//   pwm_in       asynchronous PWM line from the servo receiver
//   out_ready    consumer accepts the measurement currently held
//   out_valid    a measurement is held on pulse_width / period
//   pulse_width  high time of the last complete PWM cycle, in CLK cycles
//   period       rising-edge-to-rising-edge time, in CLK cycles
//   range_err    held pulse_width lies outside [MIN_PULSE, MAX_PULSE]
//   overrun      sticky: an unaccepted measurement was overwritten
//   timeout      sticky: no edge seen for TIMEOUT_CYC cycles
module servo_pwm_decoder #(
  parameter int CNT_W       = 32,
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 250000,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pwm_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             range_err,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_cnt, high_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_nxt;
  logic             sync1, sync2, sync3;
  logic [2:0]       prime;
  logic             rise_det, fall_det;
  logic             publish, timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Two flops to synchronize pwm_in, a third to hold the previous level.
  // prime fills with ones behind the data so edges are only trusted once
  // sync3 holds a real sample; otherwise the zeros left by reset would
  // fake a rising edge whenever pwm_in is high as reset is released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      prime <= 3'b000;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      sync3 <= sync2;
      prime <= {prime[1:0], 1'b1};
    end
  end

  assign rise_det = prime[2] &  sync2 & ~sync3;
  assign fall_det = prime[2] & ~sync2 &  sync3;

  // Next-state logic: counters, publish strobe and loss-of-signal detection.
  always_comb begin
    state_nxt   = state;
    high_nxt    = high_cnt;
    per_nxt     = per_cnt;
    publish     = 1'b0;
    idle_nxt    = (rise_det || fall_det) ? '0 : sat_inc(idle_cnt);
    timeout_hit = !(rise_det || fall_det) && (idle_nxt == TMO_VAL);

    case (state)
      SYNC_WAIT: begin
        if (rise_det) begin
          high_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          per_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        per_nxt = sat_inc(per_cnt);
        if (fall_det) begin
          state_nxt = MEAS_LOW;
        end else begin
          high_nxt = sat_inc(high_cnt);
        end
      end
      MEAS_LOW: begin
        per_nxt = sat_inc(per_cnt);
        if (rise_det) begin
          publish   = 1'b1;
          high_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
          per_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt = MEAS_HIGH;
        end
      end
      default: state_nxt = SYNC_WAIT;
    endcase

    // Loss of signal throws away whatever partial cycle was in progress.
    if (timeout_hit) begin
      state_nxt = SYNC_WAIT;
      high_nxt  = '0;
      per_nxt   = '0;
      publish   = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= SYNC_WAIT;
      high_cnt <= '0;
      per_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      high_cnt <= high_nxt;
      per_cnt  <= per_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Output holding register with valid/ready handshake and sticky flags.
  // A publish always wins: it reloads the data and keeps out_valid high;
  // overrun only flags a publish that lands on data nobody accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid   <= 1'b0;
      pulse_width <= '0;
      period      <= '0;
      range_err   <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (publish) begin
        out_valid   <= 1'b1;
        pulse_width <= high_cnt;
        period      <= per_cnt;
        range_err   <= (high_cnt < MIN_P) || (high_cnt > MAX_P);
        timeout     <= 1'b0;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
          overrun <= 1'b0;
        end
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          overrun   <= 1'b0;
        end
        if (timeout_hit) begin
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule
